galaga_input_ctrl: RTL and testbench



---
 rtl/galaga_input_pkg.sv | 24 ++
 rtl/input_seq_timer.sv | 29 ++
 rtl/galaga_input_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_galaga_input_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/galaga_input_pkg.sv
// Shared constants for the galaga input conditioning stage: PS/2 scancodes,
// joystick bit positions and the coin/start sequencer states.
package galaga_input_pkg;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_CTRL  = 8'h14;
    localparam logic [7:0] KEY_F1    = 8'h05;
    localparam logic [7:0] KEY_F2    = 8'h06;

    localparam int unsigned JOY_RIGHT  = 0;
    localparam int unsigned JOY_LEFT   = 1;
    localparam int unsigned JOY_DOWN   = 2;
    localparam int unsigned JOY_UP     = 3;
    localparam int unsigned JOY_FIRE   = 4;
    localparam int unsigned JOY_START1 = 5;
    localparam int unsigned JOY_START2 = 6;

    typedef enum logic [1:0] {IDLE, COIN, GAP, START} seq_state_t;

endpackage

// File: rtl/input_seq_timer.sv
// Loadable down-counter with a zero flag; decrements saturate at zero.
module input_seq_timer #(
    parameter int unsigned TMR_W = 24
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             dec,
    output logic [TMR_W-1:0] count,
    output logic             zero
);

    logic [TMR_W-1:0] count_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/galaga_input_ctrl.sv
// PS/2 + joystick input conditioning and coin/start sequencer for the galaga core.
// Define AUTOFIRE_EN to turn a held fire request into a square wave.
module galaga_input_ctrl
    import galaga_input_pkg::*;
#(
    parameter int unsigned COIN_ON_CYC  = 1800000,
    parameter int unsigned COIN_GAP_CYC = 3600000,
    parameter int unsigned START_CYC    = 1800000,
    parameter int unsigned AUTOFIRE_CYC = 1200000,
    parameter int unsigned TMR_W        = 24
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate,
    output logic        coin,
    output logic        start1,
    output logic        start2,
    output logic        left,
    output logic        right,
    output logic        fire,
    output logic        busy
);

    localparam logic [TMR_W-1:0] COIN_RELOAD  = TMR_W'(COIN_ON_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_RELOAD   = TMR_W'(COIN_GAP_CYC - 1);
    localparam logic [TMR_W-1:0] START_RELOAD = TMR_W'(START_CYC - 1);

    logic [15:0] joy;
    assign joy = joystick_0 | joystick_1;

    // PS/2 event decode and key latches
    logic old_tog_q, primed_q, ps2_evt;
    logic key_up_q, key_down_q, key_left_q, key_right_q;
    logic key_space_q, key_ctrl_q, key_f1_q, key_f2_q;

    assign ps2_evt = primed_q && (ps2_key[10] != old_tog_q);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            old_tog_q   <= 1'b0;
            primed_q    <= 1'b0;
            key_up_q    <= 1'b0;
            key_down_q  <= 1'b0;
            key_left_q  <= 1'b0;
            key_right_q <= 1'b0;
            key_space_q <= 1'b0;
            key_ctrl_q  <= 1'b0;
            key_f1_q    <= 1'b0;
            key_f2_q    <= 1'b0;
        end else begin
            old_tog_q <= ps2_key[10];
            primed_q  <= 1'b1;
            if (ps2_evt) begin
                // Arrows arrive with or without the E0 prefix; the rest must be plain.
                case (ps2_key[7:0])
                    KEY_UP:    key_up_q    <= ps2_key[9];
                    KEY_DOWN:  key_down_q  <= ps2_key[9];
                    KEY_LEFT:  key_left_q  <= ps2_key[9];
                    KEY_RIGHT: key_right_q <= ps2_key[9];
                    KEY_SPACE: if (!ps2_key[8]) key_space_q <= ps2_key[9];
                    KEY_CTRL:  if (!ps2_key[8]) key_ctrl_q  <= ps2_key[9];
                    KEY_F1:    if (!ps2_key[8]) key_f1_q    <= ps2_key[9];
                    KEY_F2:    if (!ps2_key[8]) key_f2_q    <= ps2_key[9];
                    default: ;
                endcase
            end
        end
    end

    // Direction merge and orientation remap
    logic left_d, right_d, fire_raw;
    logic left_q, right_q, fire_q;

    always_comb begin
        left_d  = key_left_q | joy[JOY_LEFT];
        right_d = key_right_q | joy[JOY_RIGHT];
        if (rotate) begin
            left_d  = key_down_q | joy[JOY_DOWN];
            right_d = key_up_q | joy[JOY_UP];
        end
    end

    assign fire_raw = key_space_q | key_ctrl_q | joy[JOY_FIRE];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

`ifdef AUTOFIRE_EN
    logic             af_held_q, af_load, af_dec, af_zero;
    logic [TMR_W-1:0] af_count;

    // Reload on release, on the press edge and on every phase flip.
    assign af_load = !fire_raw || !af_held_q || af_zero;
    assign af_dec  = fire_raw && af_held_q && !af_zero;

    input_seq_timer #(
        .TMR_W(TMR_W)
    ) u_af_timer (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .load    (af_load),
        .load_val(TMR_W'(AUTOFIRE_CYC - 1)),
        .dec     (af_dec),
        .count   (af_count),
        .zero    (af_zero)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_held_q <= 1'b0;
            fire_q    <= 1'b0;
        end else begin
            af_held_q <= fire_raw;
            if (!fire_raw) begin
                fire_q <= 1'b0;
            end else if (!af_held_q) begin
                fire_q <= 1'b1;
            end else if (af_zero) begin
                fire_q <= !fire_q;
            end
        end
    end
`else
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            fire_q <= 1'b0;
        end else begin
            fire_q <= fire_raw;
        end
    end
`endif

    // Start requests and rising-edge detection
    logic s1, s2, s1_q, s2_q, s1_rise, s2_rise;

    assign s1      = key_f1_q | joy[JOY_START1];
    assign s2      = key_f2_q | joy[JOY_START2];
    assign s1_rise = s1 & ~s1_q;
    assign s2_rise = s2 & ~s2_q;

    // Coin/start sequencer
    seq_state_t       state_q, state_d;
    logic             sel_p2_q, sel_p2_d;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0] tmr_val, seq_count;

    input_seq_timer #(
        .TMR_W(TMR_W)
    ) u_seq_timer (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .dec     (tmr_dec),
        .count   (seq_count),
        .zero    (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        sel_p2_d = sel_p2_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Edges outside IDLE are dropped rather than queued.
                if (s1_rise || s2_rise) begin
                    state_d  = COIN;
                    sel_p2_d = !s1_rise;
                    tmr_load = 1'b1;
                    tmr_val  = COIN_RELOAD;
                end
            end
            COIN: begin
                if (tmr_zero) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_RELOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    state_d  = START;
                    tmr_load = 1'b1;
                    tmr_val  = START_RELOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            START: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sel_p2_q <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_p2_q <= sel_p2_d;
            s1_q     <= s1;
            s2_q     <= s2;
        end
    end

    logic idle;
    assign idle   = (state_q == IDLE);
    assign coin   = (state_q == COIN);
    assign busy   = !idle;
    assign start1 = ((state_q == START) && !sel_p2_q) || (s1 && idle);
    assign start2 = ((state_q == START) && sel_p2_q) || (s2 && idle);
    assign left   = left_q;
    assign right  = right_q;
    assign fire   = fire_q;

    logic unused_bits;
`ifdef AUTOFIRE_EN
    assign unused_bits = ^{joy[15:7], seq_count, af_count};
`else
    assign unused_bits = ^{joy[15:7], seq_count};
`endif

endmodule

// File: tb/tb_galaga_input_ctrl.sv
// Scoreboard bench for galaga_input_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_galaga_input_ctrl;
    import galaga_input_pkg::*;

    localparam int B_COIN = 6, B_S1 = 5, B_S2 = 4, B_L = 3, B_R = 2, B_F = 1, B_BUSY = 0;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [15:0] joystick_0 = '0;
    logic [15:0] joystick_1 = '0;
    logic        rotate = 1'b0;
    logic        coin, start1, start2, left, right, fire, busy;
    logic        tog = 1'b0;

    galaga_input_ctrl #(
        .COIN_ON_CYC (4),
        .COIN_GAP_CYC(3),
        .START_CYC   (5),
        .AUTOFIRE_CYC(2),
        .TMR_W       (24)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .joystick_0(joystick_0),
        .joystick_1(joystick_1),
        .rotate    (rotate),
        .coin      (coin),
        .start1    (start1),
        .start2    (start2),
        .left      (left),
        .right     (right),
        .fire      (fire),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [6:0] mask;
        logic [6:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic logic [6:0] outs();
        return {coin, start1, start2, left, right, fire, busy};
    endfunction

    task automatic check(input string name, input logic [6:0] mask, input logic [6:0] act,
                         input logic [6:0] exp);
        n_checks++;
        if ((act & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %b want %b (mask %b)", name, cyc, act & mask,
                     exp & mask, mask);
        end
    endtask

    // Expect output bit 'b' to equal 'v' after 'dly' more clock edges.
    task automatic expect_bit(input int dly, input int b, input logic v, input string name);
        exp_t e;
        e.at   = cyc + dly;
        e.mask = 7'(1 << b);
        e.val  = v ? e.mask : 7'd0;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_range(input int from, input int to, input int b, input logic v,
                                input string name);
        for (int d = from; d <= to; d++) expect_bit(d, b, v, name);
    endtask

    always @(negedge clk_sys) begin
        exp_t keep[$];
        keep.delete();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].at == cyc) begin
                check(sb[i].name, sb[i].mask, outs(), sb[i].val);
            end else if (sb[i].at < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].name,
                         sb[i].at);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ps2_event(input logic pressed, input logic ext, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, pressed, ext, code};
    endtask

    initial begin
        tick();
        tick();
        check("reset_outputs", 7'h7F, outs(), 7'h00);
        reset_n = 1'b1;
        tick();
        tick();

        // Key latency, plain and extended left arrow
        ps2_event(1'b1, 1'b0, KEY_LEFT);
        expect_bit(1, B_L, 1'b0, "key_left_n1");
        expect_bit(2, B_L, 1'b1, "key_left_n2");
        tick(); tick();
        ps2_event(1'b0, 1'b0, KEY_LEFT);
        expect_bit(1, B_L, 1'b1, "key_left_rel_n1");
        expect_bit(2, B_L, 1'b0, "key_left_rel_n2");
        tick(); tick();
        ps2_event(1'b1, 1'b1, KEY_LEFT);
        expect_bit(2, B_L, 1'b1, "key_left_ext");
        tick(); tick();
        ps2_event(1'b0, 1'b1, KEY_LEFT);
        expect_bit(2, B_L, 1'b0, "key_left_ext_rel");
        tick(); tick();
        ps2_event(1'b1, 1'b1, KEY_SPACE);
        expect_bit(2, B_F, 1'b0, "ext_space_ignored");
        tick(); tick();

        // Rotation
        joystick_1[3] = 1'b1;
        rotate = 1'b1;
        expect_bit(1, B_R, 1'b1, "rot_up_is_right");
        tick();
        rotate = 1'b0;
        expect_bit(1, B_R, 1'b0, "norot_up_not_right");
        tick();
        joystick_1[3] = 1'b0;
        joystick_0[2] = 1'b1;
        rotate = 1'b1;
        expect_bit(1, B_L, 1'b1, "rot_down_is_left");
        tick();
        joystick_0[2] = 1'b0;
        rotate = 1'b0;
        tick(); tick();

        // Full coin/start sequence from a one-cycle joystick start1 pulse
        joystick_0[5] = 1'b1;
        expect_bit(0, B_S1, 1'b1, "seq_passthru");
        expect_bit(0, B_BUSY, 1'b0, "seq_idle");
        expect_range(1, 4, B_COIN, 1'b1, "seq_coin_on");
        expect_range(5, 7, B_COIN, 1'b0, "seq_gap");
        expect_range(1, 7, B_S1, 1'b0, "seq_no_start_yet");
        expect_range(8, 12, B_S1, 1'b1, "seq_start1");
        expect_range(8, 12, B_S2, 1'b0, "seq_start2_low");
        expect_range(1, 12, B_BUSY, 1'b1, "seq_busy");
        expect_bit(13, B_BUSY, 1'b0, "seq_done_busy");
        expect_bit(13, B_S1, 1'b0, "seq_done_start1");
        tick();
        joystick_0[5] = 1'b0;
        for (int i = 0; i < 14; i++) tick();

        // Simultaneous starts, then an F2 press during GAP that must be dropped
        ps2_event(1'b1, 1'b0, KEY_F1);
        tick();
        joystick_0[6] = 1'b1;
        expect_bit(0, B_S1, 1'b1, "sim_pass_s1");
        expect_bit(0, B_S2, 1'b1, "sim_pass_s2");
        expect_range(1, 4, B_COIN, 1'b1, "sim_coin_on");
        expect_range(5, 7, B_COIN, 1'b0, "sim_gap");
        expect_range(8, 12, B_S1, 1'b1, "sim_start1");
        expect_range(8, 12, B_S2, 1'b0, "sim_start2_low");
        expect_range(13, 17, B_BUSY, 1'b0, "sim_no_second_seq");
        expect_range(13, 17, B_COIN, 1'b0, "sim_no_second_coin");
        expect_bit(13, B_S2, 1'b1, "sim_s2_passthru_idle");
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 1) joystick_0[6] = 1'b0;
            if (i == 5) ps2_event(1'b1, 1'b0, KEY_F2);
        end
        ps2_event(1'b0, 1'b0, KEY_F1);
        tick();
        ps2_event(1'b0, 1'b0, KEY_F2);
        tick(); tick();

`ifdef AUTOFIRE_EN
        joystick_0[4] = 1'b1;
        expect_bit(1, B_F, 1'b1, "af_1");
        expect_bit(2, B_F, 1'b1, "af_2");
        expect_bit(3, B_F, 1'b0, "af_3");
        expect_bit(4, B_F, 1'b0, "af_4");
        expect_bit(5, B_F, 1'b1, "af_5");
        expect_bit(6, B_F, 1'b1, "af_6");
        for (int i = 0; i < 6; i++) tick();
        joystick_0[4] = 1'b0;
        expect_bit(1, B_F, 1'b0, "af_release");
        tick(); tick();
`else
        // Space and ctrl are independent fire sources
        ps2_event(1'b1, 1'b0, KEY_SPACE);
        expect_bit(2, B_F, 1'b1, "fire_space");
        tick();
        ps2_event(1'b1, 1'b0, KEY_CTRL);
        tick();
        ps2_event(1'b0, 1'b0, KEY_SPACE);
        expect_range(1, 3, B_F, 1'b1, "fire_ctrl_holds");
        tick(); tick(); tick();
        ps2_event(1'b0, 1'b0, KEY_CTRL);
        expect_bit(1, B_F, 1'b1, "fire_ctrl_rel_n1");
        expect_bit(2, B_F, 1'b0, "fire_ctrl_rel_n2");
        tick(); tick();
`endif

        // Asynchronous reset in the middle of COIN
        ps2_event(1'b1, 1'b0, KEY_SPACE);
        tick(); tick();
        joystick_0[5] = 1'b1;
        tick();
        joystick_0[5] = 1'b0;
        check("coin_before_reset", 7'(1 << B_COIN), outs(), 7'(1 << B_COIN));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", 7'(1 << B_COIN) | 7'(1 << B_BUSY) | 7'(1 << B_F), outs(), 7'd0);
        tick();
        reset_n = 1'b1;
        expect_bit(2, B_BUSY, 1'b0, "post_reset_idle");
        expect_bit(2, B_F, 1'b0, "post_reset_no_resume");
        tick(); tick(); tick();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
